dec_pipe: RTL and testbench

DEC_PIPE -- requirements
Module: dec_pipe

---
 rtl/dec_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_dec_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec_pipe.sv
// Pipelined instruction decoder: decodes one instruction word per cycle into a registered bundle,
// with a two-word load-immediate prefix, a halt state, and a saturating count of handed-off bundles.
module dec_pipe #(
   parameter int unsigned IW  = 16,
   parameter int unsigned RAB = 2,
   parameter int unsigned CW  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_valid,
   output logic           i_ready,
   input  logic [IW-1:0]  ins,
   input  logic           flush,
   input  logic           resume,
   output logic           o_valid,
   input  logic           o_ready,
   output logic           h,
   output logic           we,
   output logic [RAB-1:0] wad,
   output logic [RAB-1:0] ra,
   output logic [RAB-1:0] rb,
   output logic [3:0]     op,
   output logic [1:0]     liop,
   output logic [IW-1:0]  iv,
   output logic           ivw,
   output logic           ill,
   output logic [CW-1:0]  cnt
);

   localparam logic [1:0] LiopLil = 2'b00;
   localparam logic [1:0] LiopLih = 2'b01;
   localparam logic [1:0] LiopImm = 2'b10;
   localparam logic [1:0] LiopThu = 2'b11;
   localparam logic [3:0] OpThb   = 4'b1111;

   typedef enum logic [1:0] {
      StRun,
      StLiwWait,
      StHalted
   } state_e;

   typedef struct packed {
      logic           h;
      logic           we;
      logic [RAB-1:0] wad;
      logic [RAB-1:0] ra;
      logic [RAB-1:0] rb;
      logic [3:0]     op;
      logic [1:0]     liop;
      logic [IW-1:0]  iv;
      logic           ivw;
      logic           ill;
   } bundle_t;

   localparam bundle_t BunRst = '{
      h:    1'b0,
      we:   1'b0,
      wad:  '0,
      ra:   '0,
      rb:   '0,
      op:   OpThb,
      liop: LiopThu,
      iv:   '0,
      ivw:  1'b0,
      ill:  1'b0
   };

   state_e          r_state;
   bundle_t         r_bun;
   logic            r_valid;
   logic [RAB-1:0]  r_liw_wad;
   logic [CW-1:0]   r_cnt;

   bundle_t         w_dec;
   bundle_t         w_liw_bun;
   logic [3:0]      w_opc;
   logic            w_is_liw;
   logic            w_is_halt;
   logic            w_acc;
   logic            w_hs;

   assign i_ready = (r_state != StHalted) && (!r_valid || o_ready);
   assign w_acc   = i_valid && i_ready;
   assign w_hs    = r_valid && o_ready;
   assign w_opc   = ins[IW-1:IW-4];

   // Address fields are 2 bits in the encoding; the cast zero-extends or keeps the LSB.
   always_comb begin
      w_dec     = BunRst;
      w_is_liw  = 1'b0;
      w_is_halt = 1'b0;
      case (w_opc)
         4'b0000: begin
            if (ins[0] && (ins[IW-5:1] == '0)) begin
               w_dec.h   = 1'b1;
               w_is_halt = 1'b1;
            end
         end
         4'b0001: begin
            w_dec.we  = 1'b1;
            w_dec.wad = RAB'(ins[9:8]);
            w_dec.op  = ins[7:4];
            w_dec.ra  = RAB'(ins[3:2]);
            w_dec.rb  = RAB'(ins[1:0]);
         end
         4'b0010: begin
            w_dec.we   = 1'b1;
            w_dec.wad  = RAB'(ins[9:8]);
            w_dec.iv   = IW'(ins[7:0]);
            w_dec.liop = LiopImm;
         end
         4'b0011: begin
            w_dec.wad = RAB'(ins[9:8]);
            w_is_liw  = 1'b1;
         end
         4'b0100, 4'b0101: begin
            w_dec.we   = 1'b1;
            w_dec.wad  = RAB'(ins[11:10]);
            w_dec.rb   = RAB'(ins[9:8]);
            w_dec.iv   = IW'(ins[7:0]);
            w_dec.liop = ins[IW-4] ? LiopLih : LiopLil;
         end
         // The opcode LSB doubles as the single ALU-op bit of the immediate form.
         4'b1000, 4'b1001: begin
            w_dec.we   = 1'b1;
            w_dec.wad  = RAB'(ins[11:10]);
            w_dec.ra   = RAB'(ins[9:8]);
            w_dec.op   = {3'b000, ins[IW-4]};
            w_dec.iv   = IW'(ins[7:0]);
            w_dec.liop = LiopImm;
         end
         default: begin
            w_dec.ill = 1'b1;
         end
      endcase
   end

   // Second word of a prefixed load is taken raw, never decoded.
   always_comb begin
      w_liw_bun      = BunRst;
      w_liw_bun.we   = 1'b1;
      w_liw_bun.wad  = r_liw_wad;
      w_liw_bun.iv   = ins;
      w_liw_bun.ivw  = 1'b1;
      w_liw_bun.liop = LiopImm;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StRun;
         r_bun     <= BunRst;
         r_valid   <= 1'b0;
         r_liw_wad <= '0;
         r_cnt     <= '0;
      end else begin
         if (w_hs && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (flush) begin
            r_valid <= 1'b0;
            if (r_state == StLiwWait) begin
               r_state <= StRun;
            end else if ((r_state == StHalted) && resume) begin
               r_state <= StRun;
            end
         end else begin
            case (r_state)
               StRun: begin
                  if (w_acc) begin
                     if (w_is_liw) begin
                        r_liw_wad <= w_dec.wad;
                        r_valid   <= 1'b0;
                        r_state   <= StLiwWait;
                     end else begin
                        r_bun   <= w_dec;
                        r_valid <= 1'b1;
                        if (w_is_halt) begin
                           r_state <= StHalted;
                        end
                     end
                  end else if (w_hs) begin
                     r_valid <= 1'b0;
                  end
               end
               StLiwWait: begin
                  if (w_acc) begin
                     r_bun   <= w_liw_bun;
                     r_valid <= 1'b1;
                     r_state <= StRun;
                  end else if (w_hs) begin
                     r_valid <= 1'b0;
                  end
               end
               StHalted: begin
                  if (w_hs) begin
                     r_valid <= 1'b0;
                  end
                  if (resume) begin
                     r_state <= StRun;
                  end
               end
               default: begin
                  r_state <= StRun;
               end
            endcase
         end
      end
   end

   assign o_valid = r_valid;
   assign h       = r_bun.h;
   assign we      = r_bun.we;
   assign wad     = r_bun.wad;
   assign ra      = r_bun.ra;
   assign rb      = r_bun.rb;
   assign op      = r_bun.op;
   assign liop    = r_bun.liop;
   assign iv      = r_bun.iv;
   assign ivw     = r_bun.ivw;
   assign ill     = r_bun.ill;
   assign cnt     = r_cnt;

endmodule

// File: tb/tb_dec_pipe.sv
// Scoreboard bench for dec_pipe: expected bundles are queued as words are driven and compared on
// each output handshake; a second instance with CW=2 shares the stimulus to exercise saturation.
module tb_dec_pipe;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        i_valid = 1'b0;
   logic        flush   = 1'b0;
   logic        resume  = 1'b0;
   logic        o_ready = 1'b1;
   logic [15:0] ins     = 16'h0;

   logic        i_ready, o_valid, h, we, ivw, ill;
   logic [1:0]  wad, ra, rb, liop;
   logic [3:0]  op;
   logic [15:0] iv, cnt;

   logic        u2_rdy, u2_valid, u2_h, u2_we, u2_ivw, u2_ill;
   logic [1:0]  u2_wad, u2_ra, u2_rb, u2_liop, u2_cnt;
   logic [3:0]  u2_op;
   logic [15:0] u2_iv;

   logic [31:0] w_bun, u2_bun;
   assign w_bun  = {h, we, wad, ra, rb, op, liop, iv, ivw, ill};
   assign u2_bun = {u2_h, u2_we, u2_wad, u2_ra, u2_rb, u2_op, u2_liop, u2_iv, u2_ivw, u2_ill};

   dec_pipe u_dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .ins(ins),
      .flush(flush), .resume(resume), .o_valid(o_valid), .o_ready(o_ready), .h(h), .we(we),
      .wad(wad), .ra(ra), .rb(rb), .op(op), .liop(liop), .iv(iv), .ivw(ivw), .ill(ill),
      .cnt(cnt)
   );

   dec_pipe #(.IW(16), .RAB(2), .CW(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(u2_rdy), .ins(ins),
      .flush(flush), .resume(resume), .o_valid(u2_valid), .o_ready(o_ready), .h(u2_h),
      .we(u2_we), .wad(u2_wad), .ra(u2_ra), .rb(u2_rb), .op(u2_op), .liop(u2_liop),
      .iv(u2_iv), .ivw(u2_ivw), .ill(u2_ill), .cnt(u2_cnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          fails  = 0;
   int          hs     = 0;
   logic [31:0] sbq[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic h_, input logic we_, input logic [1:0] wad_,
                                      input logic [1:0] ra_, input logic [1:0] rb_,
                                      input logic [3:0] op_, input logic [1:0] li_,
                                      input logic [15:0] iv_, input logic ivw_,
                                      input logic ill_);
      return {h_, we_, wad_, ra_, rb_, op_, li_, iv_, ivw_, ill_};
   endfunction

   // Handshake at the coming edge: compare against the oldest expected bundle.
   always @(negedge clk) begin : mon
      logic [31:0] e;
      if (rst_n && o_valid && o_ready) begin
         check_eq("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check_eq("bundle", 64'(w_bun), 64'(e));
            check_eq("u2_bundle", 64'(u2_bun), 64'(e));
         end
         check_eq("u2_valid", 64'(u2_valid), 64'd1);
         check_eq("cnt", 64'(cnt), 64'(hs));
         check_eq("cnt_sat", 64'(u2_cnt), 64'(hs > 3 ? 3 : hs));
         hs++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] w, input bit push, input logic [31:0] e);
      int n = 0;
      i_valid = 1'b1;
      ins     = w;
      @(negedge clk);
      while (!i_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!i_ready) begin
         check_eq("rdy_timeout", 64'(i_ready), 64'd1);
         i_valid = 1'b0;
         return;
      end
      if (push) sbq.push_back(e);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 20) begin
         n++;
         tick();
      end
      check_eq("sb_drain", 64'(sbq.size()), 64'd0);
   endtask

   logic [31:0] rst_bun;
   logic [31:0] stall_bun;
   logic [31:0] ill_bun;
   logic [15:0] w;
   int          hs_before;

   initial begin
      rst_bun   = mk(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 4'hF, 2'd3, 16'h0000, 1'b0, 1'b0);
      stall_bun = mk(1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 4'hF, 2'd2, 16'h007F, 1'b0, 1'b0);
      ill_bun   = mk(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 4'hF, 2'd3, 16'h0000, 1'b0, 1'b1);

      #12;
      check_eq("rst_bundle", 64'(w_bun), 64'(rst_bun));
      check_eq("rst_ovalid", 64'({o_valid, u2_valid}), 64'd0);
      check_eq("rst_cnt", 64'(cnt), 64'd0);
      #1 rst_n = 1'b1;
      #1 check_eq("rel_rdy", 64'({i_ready, u2_rdy}), 64'd3);
      tick();

      send(16'h1256, 1'b1, mk(1'b0, 1'b1, 2'd2, 2'd1, 2'd2, 4'h5, 2'd3, 16'h0, 1'b0, 1'b0));
      send(16'h3100, 1'b0, 32'h0);
      check_eq("liw_nobundle", 64'(o_valid), 64'd0);
      check_eq("cnt_after_cal", 64'(cnt), 64'd1);
      send(16'hBEEF, 1'b1, mk(1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 4'hF, 2'd2, 16'hBEEF, 1'b1, 1'b0));
      send(16'h3200, 1'b0, 32'h0);
      send(16'h0001, 1'b1, mk(1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 4'hF, 2'd2, 16'h0001, 1'b1, 1'b0));
      check_eq("liw_nohalt", 64'({i_ready, u2_rdy}), 64'd3);

      send(16'h0001, 1'b1, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 4'hF, 2'd3, 16'h0, 1'b0, 1'b0));
      i_valid = 1'b1;
      ins     = 16'h1256;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("halt_rdy", 64'({i_ready, u2_rdy}), 64'd0);
      end
      check_eq("halt_ovalid", 64'(o_valid), 64'd0);
      i_valid = 1'b0;
      resume  = 1'b1;
      tick();
      resume = 1'b0;
      check_eq("resume_rdy", 64'({i_ready, u2_rdy}), 64'd3);
      send(16'h4A12, 1'b1, mk(1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 4'hF, 2'd0, 16'h0012, 1'b0, 1'b0));
      send(16'h5A12, 1'b1, mk(1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 4'hF, 2'd1, 16'h0012, 1'b0, 1'b0));
      drain();

      o_ready = 1'b0;
      send(16'h217F, 1'b1, stall_bun);
      hs_before = hs;
      for (int i = 0; i < 3; i++) begin
         check_eq("stall_bundle", 64'(w_bun), 64'(stall_bun));
         check_eq("stall_vr", 64'({o_valid, i_ready}), 64'd2);
         check_eq("stall_cnt", 64'(cnt), 64'(hs_before));
         tick();
      end
      o_ready = 1'b1;
      tick();
      check_eq("stall_cnt_inc", 64'(cnt), 64'(hs_before + 1));

      // Back-to-back CALs exercise replacement without bubbles.
      for (int i = 0; i < 8; i++) begin
         w = {4'b0001, 12'($urandom)};
         send(w, 1'b1, mk(1'b0, 1'b1, w[9:8], w[3:2], w[1:0], w[7:4], 2'd3, 16'h0, 1'b0, 1'b0));
      end
      drain();

      send(16'h3300, 1'b0, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      send(16'h9405, 1'b1, mk(1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 4'h1, 2'd2, 16'h0005, 1'b0, 1'b0));
      send(16'h8C33, 1'b1, mk(1'b0, 1'b1, 2'd3, 2'd0, 2'd0, 4'h0, 2'd2, 16'h0033, 1'b0, 1'b0));
      drain();

      o_ready = 1'b0;
      send(16'h2155, 1'b0, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("flush_ovalid", 64'(o_valid), 64'd0);
      o_ready = 1'b1;

      send(16'hF000, 1'b1, ill_bun);
      send(16'h6ABC, 1'b1, ill_bun);
      drain();

      send(16'h3100, 1'b0, 32'h0);
      rst_n = 1'b0;
      hs    = 0;
      #2 rst_n = 1'b1;
      #1 check_eq("rst_liw_rdy", 64'({i_ready, u2_rdy}), 64'd3);
      tick();
      send(16'h1256, 1'b1, mk(1'b0, 1'b1, 2'd2, 2'd1, 2'd2, 4'h5, 2'd3, 16'h0, 1'b0, 1'b0));
      send(16'h0001, 1'b1, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 4'hF, 2'd3, 16'h0, 1'b0, 1'b0));
      drain();
      rst_n = 1'b0;
      hs    = 0;
      #2 rst_n = 1'b1;
      #1 check_eq("rst_halt_rdy", 64'({i_ready, u2_rdy}), 64'd3);
      tick();

      for (int i = 0; i < 5; i++) begin
         w = {4'b0001, 12'($urandom)};
         send(w, 1'b1, mk(1'b0, 1'b1, w[9:8], w[3:2], w[1:0], w[7:4], 2'd3, 16'h0, 1'b0, 1'b0));
      end
      drain();
      tick();
      check_eq("cnt_final", 64'(cnt), 64'd5);
      check_eq("cnt_sat_final", 64'(u2_cnt), 64'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
